cpu_stim_sequencer: RTL and testbench
=====================================

# cpu_stim_sequencer

Synthesisable run controller that sits in front of `cpu_top`: it sequences the CPU reset pulse, streams a preloaded stimulus buffer onto the CPU's `x1`/`x2` inputs and captures `y2` whenever `y1` is high. It is the parametrised successor to our fixed simulation reset/stimulus stub. It adds configurable reset timing, a loadable stimulus buffer of configurable depth and width, a looping replay mode and output capture.

## Interface
- `DATA_W`, 30: width of `x2`/`y2` words.
- `DEPTH`, 8: stimulus buffer entries; power of two, ≥2.
- `PRE_CYC`, 5: cycles `cpu_rst` is held low before the pulse; ≥1.
- `RST_CYC`, 5: width of the `cpu_rst` high pulse, in cycles; ≥1.
- `X1_INIT`, 1: reset/idle value of `cpu_x1`.

Ports, clock and reset first:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin sequence; accepted only in IDLE.
- `loop` in 1: replay mode; sampled when `start` is accepted.
- `stop` in 1: ends RUN; ignored in other states.
- `ld_valid` in 1, `ld_ready` out 1, `ld_data` in DATA_W+1: buffer load handshake. `ld_data[DATA_W]` is the x1 value and `ld_data[DATA_W-1:0]` is the x2 value.
- `cpu_rst` out 1: active-high reset to the CPU.
- `cpu_x1` out 1, `cpu_x2` out DATA_W: stimulus to the CPU.
- `cpu_y1` in 1, `cpu_y2` in DATA_W: CPU outputs.
- `cap_valid` out 1, `cap_data` out DATA_W, `cap_cnt` out 16: capture port.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a sequence completes.

## Operation
- **States:** IDLE → PRE → RESET → RUN → DONE → IDLE.
- **IDLE:** `cpu_rst`=0. `start` moves to PRE, latches `loop` into `loop_q` and clears `cap_cnt`.
- **PRE:** `cpu_rst`=0 for exactly PRE_CYC cycles.
- **RESET:** `cpu_rst`=1 for exactly RST_CYC cycles.
- **RUN:** `cpu_rst`=0.
  - Non-loop mode: each cycle the buffer is non-empty, one entry is popped and registered onto `cpu_x1`/`cpu_x2`. The first cycle RUN finds the buffer empty, or `stop` is asserted, moves to DONE. `cpu_x*` hold their last values.
  - Loop mode: entries are read without being consumed. The replay pointer walks rd_ptr … wr_ptr−1 and wraps back to rd_ptr. `stop` moves to DONE. If the buffer is empty, `cpu_x*` hold their values until `stop`.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Load handshake:** a transfer occurs when `ld_valid && ld_ready`.
  - `ld_ready` = (count < DEPTH) && !(state==RUN && loop_q).
  - In non-loop RUN, a simultaneous push and pop leaves count unchanged; a full buffer with a pop in the same cycle still shows `ld_ready`=0 (no bypass).
- **Pointers:** log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- **Capture:** only in RUN. When `cpu_y1`=1: `cap_data`←`cpu_y2`, `cap_valid` pulses for 1 cycle, and `cap_cnt` increments, saturating at 16'hFFFF.
- **Reset values (`rst` low, asynchronous, any state):**
  - state IDLE; buffer emptied.
  - `cpu_rst`=0, `cpu_x1`=X1_INIT, `cpu_x2`=0.
  - `cap_valid`=0, `cap_data`=0, `cap_cnt`=0.
  - `busy`=0, `done`=0, `ld_ready`=0 while `rst` is low.
- **Reset mid-operation:** aborts immediately; no `done` pulse.

## Timing
- `start` accepted at edge T gives:
  - PRE during cycles T+1 … T+PRE_CYC.
  - `cpu_rst` high during T+PRE_CYC+1 … T+PRE_CYC+RST_CYC.
  - First RUN cycle R = T+PRE_CYC+RST_CYC+1.
- Stimulus latency: an entry popped in cycle R appears on `cpu_x*` in R+1. After that, one entry per cycle with no bubbles.
- Capture latency: 1 cycle from `cpu_y1` to `cap_valid`.
- All outputs are registered except `ld_ready` and `busy`, which are combinational from state and count.
- `stop` and the empty condition seen in the same cycle both lead to DONE; there is no difference in outcome.

## Structure
- Package `cpu_seq_pkg`:
  - state enum (IDLE, PRE, RESET, RUN, DONE).
  - `CAP_CNT_W`=16.
  - phase-counter width function (clog2 of max(PRE_CYC, RST_CYC)+1).
- Sub-module `stim_fifo`: DEPTH×(DATA_W+1) storage, wr/rd pointers, count, and the non-destructive replay pointer with a `replay_rst` input that loads it from rd_ptr. The top level holds the FSM, phase counter and capture logic.

## Test plan
- **Reset timing:** PRE_CYC=5, RST_CYC=5, empty buffer, `start` at T → `cpu_rst` high exactly cycles T+6 … T+10, DONE reached, `done` pulse at T+12, `cpu_x1`=1, `cpu_x2`=0 throughout.
- **Non-loop streaming:** load 3 entries {1,0x1}, {0,0x2}, {1,0x3}, then `start` → `cpu_x*` show them in cycles R+1, R+2, R+3; `done` follows; buffer count 0.
- **Full buffer and concurrent push/pop:** load 8 entries → `ld_ready`=0; push during non-loop RUN → pushed entry streamed after the originals, in order.
- **Loop replay:** 2 entries, `loop`=1 → sequence A, B, A, B… until `stop`; `ld_ready`=0 during RUN; count still 2 after DONE.
- **Capture:** `cpu_y1` pulsed 3 times with `cpu_y2`=0x15, 0x2A, 0x3F → `cap_data` follows one cycle later each time and `cap_cnt`=3; pulses in IDLE are ignored.
- **Reset mid-run:** drop `rst` during RESET phase → `cpu_rst`=0, buffer empty and state IDLE immediately, no `done` pulse.

Source files
------------

// File: rtl/cpu_stim_sequencer_pkg.sv
// Shared types and helpers for the CPU run controller: FSM state encoding,
// capture counter width and the phase-counter width calculation.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    RESET,
    RUN,
    DONE
  } state_t;

  localparam int CAP_CNT_W = 16;

  // Wide enough to hold the longer of the two reset phases.
  function automatic int phase_w(input int pre_cyc, input int rst_cyc);
    return $clog2(((pre_cyc > rst_cyc) ? pre_cyc : rst_cyc) + 1);
  endfunction

endpackage

// File: rtl/cpu_stim_sequencer_fifo.sv
// Stimulus buffer: circular storage with a consuming read pointer and a
// separate non-destructive replay pointer used for looping playback.
module stim_fifo #(
  parameter int DATA_W = 30,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W:0]   din,
  input  logic              pop,
  input  logic              replay_rst,
  input  logic              replay_adv,
  output logic [DATA_W:0]   head,
  output logic [DATA_W:0]   replay_data,
  output logic [AW:0]       count
);

  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rp;
  logic [AW-1:0]   rp_nxt;

  assign head        = mem[rd_ptr];
  assign replay_data = mem[rp];
  assign rp_nxt      = rp + 1'b1;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rp     <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Replay walks the live window rd_ptr .. wr_ptr-1 and wraps to its start.
      if (replay_rst)
        rp <= rd_ptr;
      else if (replay_adv)
        rp <= (rp_nxt == wr_ptr) ? rd_ptr : rp_nxt;
    end
  end

endmodule

// File: rtl/cpu_stim_sequencer.sv
// Run controller in front of cpu_top: sequences the CPU reset pulse, streams
// buffered stimulus onto x1/x2 (once or looping) and captures y2 on y1.
module cpu_stim_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int   DATA_W  = 30,
  parameter int   DEPTH   = 8,
  parameter int   PRE_CYC = 5,
  parameter int   RST_CYC = 5,
  parameter logic X1_INIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 loop,
  input  logic                 stop,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [DATA_W:0]      ld_data,
  output logic                 cpu_rst,
  output logic                 cpu_x1,
  output logic [DATA_W-1:0]    cpu_x2,
  input  logic                 cpu_y1,
  input  logic [DATA_W-1:0]    cpu_y2,
  output logic                 cap_valid,
  output logic [DATA_W-1:0]    cap_data,
  output logic [CAP_CNT_W-1:0] cap_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = phase_w(PRE_CYC, RST_CYC);

  state_t          state;
  logic            loop_q;
  logic [PW-1:0]   phase;
  logic [AW:0]     count;
  logic [DATA_W:0] head;
  logic [DATA_W:0] replay_data;
  logic            empty;
  logic            in_run;
  logic            push;
  logic            pop;
  logic            replay_adv;

  assign empty      = (count == '0);
  assign in_run     = (state == RUN);
  assign pop        = in_run && !loop_q && !stop && !empty;
  assign replay_adv = in_run &&  loop_q && !stop && !empty;
  // No bypass: a full buffer refuses data even if it is popping this cycle.
  assign ld_ready   = rst && (count < (AW+1)'(DEPTH)) && !(in_run && loop_q);
  assign push       = ld_valid && ld_ready;
  assign busy       = (state != IDLE);

  stim_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .din         (ld_data),
    .pop         (pop),
    .replay_rst  (!in_run),
    .replay_adv  (replay_adv),
    .head        (head),
    .replay_data (replay_data),
    .count       (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      loop_q    <= 1'b0;
      phase     <= '0;
      cpu_rst   <= 1'b0;
      cpu_x1    <= X1_INIT;
      cpu_x2    <= '0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
      cap_cnt   <= '0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      cap_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= PRE;
            loop_q  <= loop;
            cap_cnt <= '0;
            phase   <= PW'(PRE_CYC - 1);
          end
        end
        PRE: begin
          if (phase == '0) begin
            state   <= RESET;
            cpu_rst <= 1'b1;
            phase   <= PW'(RST_CYC - 1);
          end else begin
            phase <= phase - 1'b1;
          end
        end
        RESET: begin
          if (phase == '0) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        RUN: begin
          // A looping run never drains, so only stop ends it.
          if (stop || (empty && !loop_q)) begin
            state <= DONE;
            done  <= 1'b1;
          end
          if (pop)
            {cpu_x1, cpu_x2} <= head;
          else if (replay_adv)
            {cpu_x1, cpu_x2} <= replay_data;
          if (cpu_y1) begin
            cap_valid <= 1'b1;
            cap_data  <= cpu_y2;
            if (cap_cnt != '1) cap_cnt <= cap_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_stim_sequencer.sv
// Randomised scoreboard bench for cpu_stim_sequencer against a queue-based
// model of the buffer, the reset timeline and the capture window.
module tb_cpu_stim_sequencer;

  localparam int DW   = 30;
  localparam int DEP  = 8;
  localparam int PRE  = 5;
  localparam int RSTC = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, loop = 1'b0, stop = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW:0]   ld_data = '0;
  logic          ld_ready;
  logic          cpu_rst, cpu_x1;
  logic [DW-1:0] cpu_x2;
  logic          cpu_y1 = 1'b0;
  logic [DW-1:0] cpu_y2 = '0;
  logic          cap_valid;
  logic [DW-1:0] cap_data;
  logic [15:0]   cap_cnt;
  logic          busy, done;

  cpu_stim_sequencer #(
    .DATA_W (DW), .DEPTH (DEP), .PRE_CYC (PRE), .RST_CYC (RSTC), .X1_INIT (1'b1)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .loop (loop), .stop (stop),
    .ld_valid (ld_valid), .ld_ready (ld_ready), .ld_data (ld_data),
    .cpu_rst (cpu_rst), .cpu_x1 (cpu_x1), .cpu_x2 (cpu_x2),
    .cpu_y1 (cpu_y1), .cpu_y2 (cpu_y2),
    .cap_valid (cap_valid), .cap_data (cap_data), .cap_cnt (cap_cnt),
    .busy (busy), .done (done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int kind; logic [DW:0] v; } pexp_t;
  typedef struct { int cyc; logic [DW-1:0] d; int cnt; } cexp_t;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  pexp_t       pq[$];
  cexp_t       cq[$];
  int          dq[$];
  logic [DW:0] mbuf[$];
  logic [DW:0] last_x = {1'b1, {DW{1'b0}}};
  int          ccnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW:0] b2v(input bit b);
    return {{DW{1'b0}}, b};
  endfunction

  function automatic logic [DW:0] i2v(input int i);
    return (DW+1)'(i);
  endfunction

  task automatic chk(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void expc(input int c, input int k, input logic [DW:0] v);
    pexp_t e;
    e.cyc = c; e.kind = k; e.v = v;
    pq.push_back(e);
  endfunction

  // Monitor: per-cycle expectations plus event-driven done/capture checks.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = pq.size() - 1; i >= 0; i--) begin
        if (pq[i].cyc == cyc) begin
          case (pq[i].kind)
            0:       chk("cpu_x",    {cpu_x1, cpu_x2}, pq[i].v);
            1:       chk("cpu_rst",  b2v(cpu_rst),     pq[i].v);
            2:       chk("busy",     b2v(busy),        pq[i].v);
            default: chk("ld_ready", b2v(ld_ready),    pq[i].v);
          endcase
          pq.delete(i);
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("done_unexpected", b2v(1'b1), b2v(1'b0));
        else                chk("done_cyc", i2v(cyc), i2v(dq.pop_front()));
      end
      if (cap_valid) begin
        if (cq.size() == 0) chk("cap_unexpected", b2v(1'b1), b2v(1'b0));
        else begin
          cexp_t e;
          e = cq.pop_front();
          chk("cap_cyc",  i2v(cyc),               i2v(e.cyc));
          chk("cap_data", {1'b0, cap_data},       {1'b0, e.d});
          chk("cap_cnt",  (DW+1)'(cap_cnt),       i2v(e.cnt));
        end
      end
    end
  end

  task automatic load(input logic [DW:0] e);
    ld_valid = 1'b1;
    ld_data  = e;
    chk("ld_ready_idle", b2v(ld_ready), b2v(mbuf.size() < DEP));
    if (mbuf.size() < DEP) mbuf.push_back(e);
    tick();
    ld_valid = 1'b0;
  endtask

  function automatic logic [DW:0] rnd_entry();
    return {1'($urandom_range(0, 1)), DW'($urandom)};
  endfunction

  // One start..done sequence. Timeline: start high in cycle s, PRE s+1..s+PRE,
  // cpu_rst s+PRE+1..s+PRE+RSTC, first RUN cycle R, DONE cycle D.
  task automatic run_seq(input bit lp, input int stop_len, input bit push_run);
    int          s, r, last_run, d, m;
    logic [DW:0] e;
    logic [DW:0] l[$];
    s = cyc;
    start = 1'b1;
    loop  = lp;
    ccnt  = 0;
    r = s + PRE + RSTC + 1;
    e = rnd_entry();
    l = mbuf;
    expc(r, 3, b2v(!lp && (mbuf.size() < DEP)));
    if (!lp && push_run) l.push_back(e);
    m = l.size();
    last_run = lp ? r + stop_len : r + m;
    d = last_run + 1;
    for (int c = s + 1; c <= r; c++) begin
      expc(c, 1, b2v((c > s + PRE) && (c <= s + PRE + RSTC)));
      expc(c, 2, b2v(1'b1));
      expc(c, 0, last_x);
    end
    if (!lp) begin
      for (int i = 0; i < m; i++) expc(r + 1 + i, 0, l[i]);
      if (m > 0) last_x = l[m-1];
      mbuf.delete();
    end else begin
      for (int c = r + 1; c <= last_run; c++) begin
        if (m > 0) last_x = l[(c - r - 1) % m];
        expc(c, 0, last_x);
      end
    end
    expc(d, 0, last_x);
    expc(d, 2, b2v(1'b1));
    expc(d + 1, 2, b2v(1'b0));
    dq.push_back(d);
    tick();
    start = 1'b0;
    for (int c = s + 1; c <= d + 1; c++) begin
      cpu_y1 = 1'($urandom_range(0, 1));
      cpu_y2 = DW'($urandom);
      if (cpu_y1 && c >= r && c <= last_run) begin
        cexp_t ce;
        ccnt = (ccnt < 65535) ? ccnt + 1 : ccnt;
        ce.cyc = c + 1; ce.d = cpu_y2; ce.cnt = ccnt;
        cq.push_back(ce);
      end
      stop = lp && (c == last_run);
      if (push_run && !lp && c == r + 1) begin
        ld_valid = 1'b1;
        ld_data  = e;
        chk("ld_ready_run", b2v(ld_ready), b2v(1'b1));
      end else begin
        ld_valid = 1'b0;
      end
      tick();
    end
    cpu_y1 = 1'b0; stop = 1'b0; ld_valid = 1'b0; loop = 1'b0;
    chk("cap_cnt_final", (DW+1)'(cap_cnt), i2v(ccnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit lp;
    repeat (3) tick();
    chk("rst_cpu_rst",   b2v(cpu_rst),           b2v(1'b0));
    chk("rst_cpu_x",     {cpu_x1, cpu_x2},       {1'b1, {DW{1'b0}}});
    chk("rst_cap_valid", b2v(cap_valid),         b2v(1'b0));
    chk("rst_cap_data",  {1'b0, cap_data},       '0);
    chk("rst_cap_cnt",   (DW+1)'(cap_cnt),       '0);
    chk("rst_busy",      b2v(busy),              b2v(1'b0));
    chk("rst_done",      b2v(done),              b2v(1'b0));
    chk("rst_ld_ready",  b2v(ld_ready),          b2v(1'b0));
    rst = 1'b1;
    repeat (2) tick();

    // Empty buffer: reset timeline only.
    run_seq(1'b0, 0, 1'b0);

    // Three-entry one-shot stream.
    load({1'b1, DW'(1)});
    load({1'b0, DW'(2)});
    load({1'b1, DW'(3)});
    run_seq(1'b0, 0, 1'b0);

    // Full buffer, refused extra load, push while streaming.
    for (int i = 0; i < DEP; i++) load(rnd_entry());
    load(rnd_entry());
    run_seq(1'b0, 0, 1'b1);

    // Loop replay of two entries, then drain them to show they survived.
    load(rnd_entry());
    load(rnd_entry());
    run_seq(1'b1, 7, 1'b0);
    run_seq(1'b0, 0, 1'b0);

    // Capture pulses while idle must be ignored.
    for (int i = 0; i < 4; i++) begin
      cpu_y1 = 1'b1;
      cpu_y2 = DW'(8'h15 * (i + 1));
      tick();
    end
    cpu_y1 = 1'b0;
    tick();

    // Randomised sequences.
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(0, DEP - mbuf.size());
      for (int i = 0; i < n; i++) load(rnd_entry());
      lp = 1'($urandom_range(0, 1));
      run_seq(lp, $urandom_range(1, 12), !lp && mbuf.size() >= 2 && 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end

    // Reset dropped during the cpu_rst pulse.
    load(rnd_entry());
    load(rnd_entry());
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (PRE + 1) tick();
    chk("mid_cpu_rst_before", b2v(cpu_rst), b2v(1'b1));
    #2 rst = 1'b0;
    #1;
    chk("mid_cpu_rst",  b2v(cpu_rst),     b2v(1'b0));
    chk("mid_busy",     b2v(busy),        b2v(1'b0));
    chk("mid_ld_ready", b2v(ld_ready),    b2v(1'b0));
    chk("mid_cpu_x",    {cpu_x1, cpu_x2}, {1'b1, {DW{1'b0}}});
    mbuf.delete();
    last_x = {1'b1, {DW{1'b0}}};
    tick();
    rst = 1'b1;
    repeat (3) tick();
    run_seq(1'b0, 0, 1'b0);

    repeat (3) tick();
    chk("cap_queue_empty",  i2v(cq.size()), '0);
    chk("done_queue_empty", i2v(dq.size()), '0);
    chk("cyc_queue_empty",  i2v(pq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
